// File: rtl/ipsmacge_rxsfd.sv
// ---------------------------------------------------------------------------
// ipsmacge_rxsfd
// Receive preamble/SFD stripper and frame delimiter for the triple-speed GE
// MAC. Consumes the PHY receive byte stream, removes preamble and SFD, marks
// first/last payload bytes and reports per-frame error flag and byte length.
//
// Ports
//   rxclk   in   receive clock
//   rxrst   in   synchronous active-high reset
//   igval   in   input byte strobe
//   igdat   in   input byte
//   igdv    in   data valid (frame boundary), sampled every cycle
//   iger    in   receive error, sampled every cycle
//   up_act  in   port enable
//   oval    out  output byte strobe
//   odat    out  payload byte
//   osof    out  first payload byte (qualified by oval)
//   oeof    out  last payload byte (qualified by oval)
//   oerr    out  frame error, valid with oeof
//   olen    out  payload byte count, valid with oeof
//   oprerr  out  pulse: preamble error, frame dropped
//   ofrmok  out  pulse: frame ended without error
//
// Build option
//   IPSMACGE_RXSFD_LENCHK_EN : flag frames shorter than MIN_LEN or longer
//                              than MAX_LEN (saturated count counts as long).
// ---------------------------------------------------------------------------
module ipsmacge_rxsfd #(
    parameter int DAT_DW  = 8,
    parameter int LEN_DW  = 14,
    parameter int PRE_MAX = 8,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic              rxclk,
    input  logic              rxrst,
    input  logic              igval,
    input  logic [DAT_DW-1:0] igdat,
    input  logic              igdv,
    input  logic              iger,
    input  logic              up_act,
    output logic              oval,
    output logic [DAT_DW-1:0] odat,
    output logic              osof,
    output logic              oeof,
    output logic              oerr,
    output logic [LEN_DW-1:0] olen,
    output logic              oprerr,
    output logic              ofrmok
);

    localparam int                PC_W     = $clog2(PRE_MAX + 1);
    localparam logic [PC_W:0]     PRE_LIM  = (PC_W + 1)'(PRE_MAX);
    localparam logic [DAT_DW-1:0] PRE_BYTE = DAT_DW'(8'h55);
    localparam logic [DAT_DW-1:0] SFD_BYTE = DAT_DW'(8'hD5);

    if (MIN_LEN > MAX_LEN) begin : g_len_cfg_chk
        $error("ipsmacge_rxsfd: MIN_LEN must not exceed MAX_LEN");
    end

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_cur;
    logic [PC_W:0]     pc_inc;
    logic [LEN_DW-1:0] len_q, len_d;
    logic [DAT_DW-1:0] hold_q, hold_d;
    logic              held_q, held_d;
    logic              first_q, first_d;
    logic              err_q, err_d;
    logic              len_bad;
    logic              end_err;

    logic              oval_q, oval_d;
    logic [DAT_DW-1:0] odat_q, odat_d;
    logic              osof_q, osof_d;
    logic              oeof_q, oeof_d;
    logic              oerr_q, oerr_d;
    logic [LEN_DW-1:0] olen_q, olen_d;
    logic              oprerr_q, oprerr_d;
    logic              ofrmok_q, ofrmok_d;

`ifdef IPSMACGE_RXSFD_LENCHK_EN
    assign len_bad = (len_q < LEN_DW'(MIN_LEN)) || (len_q > LEN_DW'(MAX_LEN)) || (&len_q);
`else
    assign len_bad = 1'b0;
`endif

    // iger on the end cycle itself still belongs to the frame
    assign end_err = err_q | iger | len_bad;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        hold_d   = hold_q;
        held_d   = held_q;
        first_d  = first_q;
        err_d    = err_q;
        oval_d   = 1'b0;
        odat_d   = odat_q;
        osof_d   = 1'b0;
        oeof_d   = 1'b0;
        oerr_d   = 1'b0;
        olen_d   = '0;
        oprerr_d = 1'b0;
        ofrmok_d = 1'b0;

        // IDLE processes its igdv=1 byte as the first preamble byte, so the
        // counter seen in that cycle is zero.
        pc_cur = (state_q == S_IDLE) ? '0 : pc_q;
        pc_inc = {1'b0, pc_cur} + (PC_W + 1)'(1);

        if (!up_act) begin
            state_d = S_IDLE;
            held_d  = 1'b0;
            if (state_q == S_DATA && held_q) begin
                oval_d = 1'b1;
                odat_d = hold_q;
                osof_d = first_q;
                oeof_d = 1'b1;
                oerr_d = 1'b1;
                olen_d = len_q;
            end
        end else begin
            case (state_q)
                S_IDLE, S_PRE: begin
                    if (!igdv) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PRE;
                        pc_d    = pc_cur;
                        if (igval) begin
                            if (igdat == SFD_BYTE) begin
                                state_d = S_DATA;
                                len_d   = '0;
                                first_d = 1'b1;
                                err_d   = 1'b0;
                                held_d  = 1'b0;
                            end else if (igdat == PRE_BYTE && pc_inc < PRE_LIM) begin
                                pc_d = pc_inc[PC_W-1:0];
                            end else begin
                                state_d  = S_DROP;
                                oprerr_d = 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    err_d = err_q | iger;
                    if (igdv) begin
                        if (igval) begin
                            // one-byte holding register lets the last byte carry eof
                            hold_d = igdat;
                            held_d = 1'b1;
                            if (!(&len_q)) begin
                                len_d = len_q + LEN_DW'(1);
                            end
                            if (held_q) begin
                                oval_d  = 1'b1;
                                odat_d  = hold_q;
                                osof_d  = first_q;
                                first_d = 1'b0;
                            end
                        end
                    end else begin
                        state_d = S_IDLE;
                        held_d  = 1'b0;
                        if (held_q) begin
                            oval_d   = 1'b1;
                            odat_d   = hold_q;
                            osof_d   = first_q;
                            oeof_d   = 1'b1;
                            oerr_d   = end_err;
                            olen_d   = len_q;
                            ofrmok_d = ~end_err;
                        end
                    end
                end
                S_DROP: begin
                    if (!igdv) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge rxclk) begin
        if (rxrst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            hold_q   <= '0;
            held_q   <= 1'b0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
            oval_q   <= 1'b0;
            odat_q   <= '0;
            osof_q   <= 1'b0;
            oeof_q   <= 1'b0;
            oerr_q   <= 1'b0;
            olen_q   <= '0;
            oprerr_q <= 1'b0;
            ofrmok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            hold_q   <= hold_d;
            held_q   <= held_d;
            first_q  <= first_d;
            err_q    <= err_d;
            oval_q   <= oval_d;
            odat_q   <= odat_d;
            osof_q   <= osof_d;
            oeof_q   <= oeof_d;
            oerr_q   <= oerr_d;
            olen_q   <= olen_d;
            oprerr_q <= oprerr_d;
            ofrmok_q <= ofrmok_d;
        end
    end

    assign oval   = oval_q;
    assign odat   = odat_q;
    assign osof   = osof_q;
    assign oeof   = oeof_q;
    assign oerr   = oerr_q;
    assign olen   = olen_q;
    assign oprerr = oprerr_q;
    assign ofrmok = ofrmok_q;

endmodule

// File: doc/ipsmacge_rxsfd.md
# ipsmacge_rxsfd

Receive preamble/SFD stripper and frame delimiter for the triple-speed GE MAC. It sits directly downstream of the PHY receive interface stage and consumes its byte stream: valid strobe, data, data-valid and error. It removes the preamble and SFD, marks start and end of frame on the payload bytes, accumulates a per-frame error flag and byte length, and pulses status events for the CPU counters.

## Interface
Parameters:
- DAT_DW, 8, byte width
- LEN_DW, 14, frame length counter width
- PRE_MAX, 8, max valid bytes before SFD (preamble + SFD) before the frame is dropped
- MIN_LEN, 64, minimum frame length in bytes, used only with the length check
- MAX_LEN, 1518, maximum frame length in bytes, used only with the length check

Ports:
- rxclk  in  1  receive clock (125/25/2.5 MHz)
- rxrst  in  1  reset, synchronous, active-high
- igval  in  1  input byte strobe (every cycle at 1000, every other cycle at 10/100)
- igdat  in  DAT_DW  input byte, meaningful when igval=1
- igdv  in  1  data valid; frame boundary, sampled every cycle
- iger  in  1  receive error, sampled every cycle
- up_act  in  1  port enable
- oval  out  1  output byte strobe
- odat  out  DAT_DW  payload byte (SFD excluded)
- osof  out  1  first payload byte, qualified by oval
- oeof  out  1  last payload byte, qualified by oval
- oerr  out  1  frame error, valid with oeof
- olen  out  LEN_DW  payload byte count, valid with oeof
- oprerr  out  1  one-cycle pulse: preamble error, frame dropped
- ofrmok  out  1  one-cycle pulse: frame ended with oerr=0

## Operation
- All outputs are registered. Reset value is 0 for every output, the state is IDLE, and the holding register is cleared.
- State machine:
  - IDLE: igdv=1 -> PRE, with the preamble counter pc cleared. The byte sampled on that cycle is processed as in PRE.
  - PRE: on each igval=1:
    - 0x55: increment pc.
    - 0xD5: go to DATA, clear the length counter, set first=1, clear the error accumulator.
    - Any other value: go to DROP and pulse oprerr.
    - If pc reaches PRE_MAX without an SFD: go to DROP and pulse oprerr.
    - igdv=0: go to IDLE with no output.
  - DATA: on each igval=1 with igdv=1:
    - The byte goes into the 1-byte holding register.
    - The previously held byte, if any, is emitted (oval=1, osof=first; first is then cleared).
    - The length counter increments and saturates at all-ones.
    - iger=1 on any DATA cycle sets the error accumulator.
  - DATA end: the first cycle with igdv=0:
    - If a byte is held: emit it with oeof=1, oerr=accumulator, olen=count. Pulse ofrmok if oerr=0.
    - If no byte is held (SFD followed by igdv drop): emit nothing.
    - Go to IDLE.
  - DROP: wait for igdv=0, then go to IDLE. No output.
- Single-byte frame: osof and oeof are asserted together.
- A new igdv=1 on the cycle right after the end cycle is accepted normally. The IDLE->PRE transition costs no extra cycle.
- up_act=0:
  - In DATA with a byte held: emit it with oeof=1 and oerr=1, then go to IDLE.
  - Otherwise go to IDLE directly.
  - While up_act=0 the block stays in IDLE and produces no output.
- rxrst=1 mid-frame: immediate return to reset state. No eof is emitted.

## Timing
- Latency: payload byte k appears on oval on the cycle after input byte k+1 is sampled. The last byte appears on the cycle after the igdv=0 cycle.
- At 1000 Mbps, oval is continuous during a frame with one cycle of extra latency. At 10/100, oval follows the igval cadence.
- oprerr and ofrmok are single-cycle pulses, aligned with the cycle in which the oeof byte or the drop decision is registered.
- There is no backpressure. The downstream block must accept every oval.

## Configuration
- IPSMACGE_RXSFD_LENCHK_EN defined:
  - At end of frame, oerr is also set when olen<MIN_LEN or olen>MAX_LEN.
  - Counter saturation counts as greater than MAX_LEN.
- Not defined: oerr reflects only iger and the up_act abort. MIN_LEN and MAX_LEN are unused.

## Test plan
- 1000 mode, igval=1 continuously, 7x0x55, 0xD5, then 64 bytes 0x00..0x3F, then igdv=0 -> 64 oval cycles. osof on 0x00, oeof on 0x3F, olen=64, oerr=0, one ofrmok pulse.
- 100 mode, igval alternating, same frame -> same byte sequence at half rate. Last byte appears 1 cycle after igdv falls.
- Preamble 0x55,0x55,0x5D -> oprerr pulse, no oval until after igdv low. The next good frame is delimited correctly.
- iger=1 for one cycle mid-frame -> oeof byte has oerr=1 and no ofrmok. The following frame has oerr=0.
- up_act dropped after 10 payload bytes -> 10 bytes emitted, the 10th with oeof=1 and oerr=1. No further output until up_act=1 and a new igdv rise.
- With IPSMACGE_RXSFD_LENCHK_EN defined: 60-byte frame and 1519-byte frame -> oerr=1 for both, with olen=60 and olen=1519. A 64-byte frame gives oerr=0.
